// File: rtl/interconnect_pkg.sv
// Shared constants and types for the global memory
// initiator: address split and read tag format.
package interconnect_pkg;
  localparam int GLOBAL_MEM_N_REQ = 4;
  localparam int N_GLOBAL_MEM_BANKS = 8;
  localparam int GLOBAL_MEM_DATA_L = 32;
  localparam int GLOBAL_MEM_PER_BANK_ADDR_L = 8;
  localparam int GLOBAL_MEM_RD_LATENCY = 1;

  localparam int BANK_SEL_L = $clog2(N_GLOBAL_MEM_BANKS);
  localparam int REQ_ADDR_L =
    GLOBAL_MEM_PER_BANK_ADDR_L + BANK_SEL_L;
  localparam int PORT_ID_L = $clog2(GLOBAL_MEM_N_REQ);

  typedef struct packed {
    logic                 vld;
    logic [PORT_ID_L-1:0] port;
  } rd_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered start pointer.
// The pointer moves past the winner; N must be a power of 2.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = 0; i < N; i++) begin
      idx = ptr + PW'(i);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= win + 1'b1;
    end
  end

endmodule

// File: rtl/global_mem_access_ctrl.sv
// Client-side initiator for the banked global memory:
// per-bank arbitration, bank drive and read return.
module global_mem_access_ctrl
  import interconnect_pkg::*;
#(
  parameter int N_REQ       = GLOBAL_MEM_N_REQ,
  parameter int N_BANKS     = N_GLOBAL_MEM_BANKS,
  parameter int DATA_L      = GLOBAL_MEM_DATA_L,
  parameter int BANK_ADDR_L = GLOBAL_MEM_PER_BANK_ADDR_L,
  parameter int RD_LATENCY  = GLOBAL_MEM_RD_LATENCY,
  parameter int ADDR_L      = BANK_ADDR_L + $clog2(N_BANKS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_BANKS-1:0]     config_bank_blk,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_wr,
  input  logic [N_REQ-1:0][ADDR_L-1:0] req_addr,
  input  logic [N_REQ-1:0][DATA_L-1:0] req_wr_data,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [N_REQ-1:0][DATA_L-1:0] rsp_data,
  output logic                   busy,
  output logic [N_BANKS-1:0][BANK_ADDR_L-1:0] global_mem_addr,
  output logic [N_BANKS-1:0][DATA_L-1:0] global_mem_wr_data,
  output logic [N_BANKS-1:0]     global_mem_wr_en,
  output logic [N_BANKS-1:0]     global_mem_rd_en,
  input  logic [N_BANKS-1:0][DATA_L-1:0] global_mem_rd_data
);

  localparam int SEL_L = $clog2(N_BANKS);
  localparam int CNT_L = $clog2(N_BANKS * (1 + RD_LATENCY) + 1);
  localparam int LAST  = RD_LATENCY;

  logic [N_BANKS-1:0][N_REQ-1:0] cand;
  logic [N_BANKS-1:0][N_REQ-1:0] grant;

  logic [N_BANKS-1:0]                  sel_any;
  logic [N_BANKS-1:0]                  sel_wr;
  logic [N_BANKS-1:0][BANK_ADDR_L-1:0] sel_row;
  logic [N_BANKS-1:0][DATA_L-1:0]      sel_data;
  logic [N_BANKS-1:0][PORT_ID_L-1:0]   sel_port;

  rd_tag_t tag [N_BANKS][RD_LATENCY+1];

  logic [N_REQ-1:0]             rv;
  logic [N_REQ-1:0][DATA_L-1:0] rd;
  logic [CNT_L-1:0]             outstanding;
  logic [CNT_L-1:0]             inc;
  logic [CNT_L-1:0]             dec;

  // Reset also masks candidates so nothing is granted in reset
  always_comb begin
    cand = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int p = 0; p < N_REQ; p++) begin
        cand[b][p] = rst && req_valid[p]
          && !config_bank_blk[b]
          && (req_addr[p][SEL_L-1:0] == SEL_L'(b));
      end
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_arb
    rr_arbiter #(.N(N_REQ)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (cand[b]),
      .grant (grant[b])
    );
  end

  always_comb begin
    req_ready = '0;
    sel_any   = '0;
    sel_wr    = '0;
    sel_row   = '0;
    sel_data  = '0;
    sel_port  = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int p = 0; p < N_REQ; p++) begin
        if (grant[b][p]) begin
          req_ready[p] = 1'b1;
          sel_any[b]   = 1'b1;
          sel_wr[b]    = req_wr[p];
          sel_row[b]   = req_addr[p][ADDR_L-1:SEL_L];
          sel_data[b]  = req_wr_data[p];
          sel_port[b]  = PORT_ID_L'(p);
        end
      end
    end
  end

  always_comb begin
    rv  = '0;
    rd  = '0;
    inc = '0;
    dec = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      inc = inc + CNT_L'(sel_any[b] & ~sel_wr[b]);
      dec = dec + CNT_L'(tag[b][LAST].vld);
      for (int p = 0; p < N_REQ; p++) begin
        if (tag[b][LAST].vld &&
            tag[b][LAST].port == PORT_ID_L'(p)) begin
          rv[p] = 1'b1;
          rd[p] = global_mem_rd_data[b];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      global_mem_addr    <= '0;
      global_mem_wr_data <= '0;
      global_mem_wr_en   <= '0;
      global_mem_rd_en   <= '0;
      rsp_valid          <= '0;
      rsp_data           <= '0;
      outstanding        <= '0;
      for (int b = 0; b < N_BANKS; b++) begin
        for (int k = 0; k <= LAST; k++) begin
          tag[b][k] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < N_BANKS; b++) begin
        global_mem_wr_en[b] <= sel_any[b] & sel_wr[b];
        global_mem_rd_en[b] <= sel_any[b] & ~sel_wr[b];
        if (sel_any[b]) begin
          global_mem_addr[b]    <= sel_row[b];
          global_mem_wr_data[b] <= sel_data[b];
        end
        tag[b][0] <= '{vld:  sel_any[b] & ~sel_wr[b],
                       port: sel_port[b]};
        for (int k = 1; k <= LAST; k++) begin
          tag[b][k] <= tag[b][k-1];
        end
      end
      rsp_valid <= rv;
      for (int p = 0; p < N_REQ; p++) begin
        if (rv[p]) begin
          rsp_data[p] <= rd[p];
        end
      end
      outstanding <= outstanding + inc - dec;
    end
  end

  // Counter tracks exactly the valid tags in flight
  assign busy = |outstanding;

endmodule
